// File: rtl/mem_line_master.sv
// mem_line_master: cache-line burst master for a single-cycle, byte-addressable,
// 16-bit memory. A request optionally writes back one dirty line and then
// optionally fills a new line, one word beat at a time, and finishes with a
// one-cycle done pulse. Every memory-side output comes straight from a register.
//
// Build option: define MEM_LINE_CWF_EN for critical-word-first fills. The fill
// then starts at the word addressed by fill_addr_i and wraps around the line.
// Without it, fills always start at word 0.
`timescale 1ns/1ps
module mem_line_master #(
   parameter int WORDS       = 4,
   parameter int ADDR_WIDTH  = 16,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_wb_i,
   input  logic                  req_fill_i,
   input  logic [ADDR_WIDTH-1:0] wb_addr_i,
   input  logic [ADDR_WIDTH-1:0] fill_addr_i,
   input  logic [16*WORDS-1:0]   wb_line_i,
   output logic [16*WORDS-1:0]   fill_line_o,
   output logic                  done_o,
   output logic                  busy_o,
   output logic                  mem_en_o,
   output logic                  mem_wr_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [15:0]           mem_wdata_o,
   input  logic [15:0]           mem_rdata_i
);

   localparam int                    IDX_W     = $clog2(WORDS);
   localparam logic [IDX_W-1:0]      CNT_LAST  = IDX_W'(WORDS - 1);
   localparam logic [3:0]            WAIT_LAST = 4'(WAIT_CYCLES);
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(2 * WORDS - 1);

   typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

   // Clear the byte-offset-within-line bits to get the line base address.
   function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [ADDR_WIDTH-1:0] a);
      return a & ~OFF_MASK;
   endfunction

   // Byte address of word idx in the line at base; wraps at 2^ADDR_WIDTH.
   function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                       input logic [IDX_W-1:0]      idx);
      return base + ADDR_WIDTH'({idx, 1'b0});
   endfunction

   state_t                  state_q,     state_d;
   logic [IDX_W-1:0]        cnt_q,       cnt_d;
   logic [3:0]              wait_q,      wait_d;
   logic [ADDR_WIDTH-1:0]   wb_base_q,   wb_base_d;
   logic [ADDR_WIDTH-1:0]   fill_base_q, fill_base_d;
   logic [16*WORDS-1:0]     wb_line_q,   wb_line_d;
   logic                    fill_flag_q, fill_flag_d;
   logic [IDX_W-1:0]        cwf_off_q,   cwf_off_d;
   logic [16*WORDS-1:0]     fill_line_q, fill_line_d;
   logic                    mem_en_q,    mem_en_d;
   logic                    mem_wr_q,    mem_wr_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q,  mem_addr_d;
   logic [15:0]             mem_wdata_q, mem_wdata_d;

   logic                    beat_last;
   logic                    line_last;
   logic [IDX_W-1:0]        fill_idx_q;
   logic [IDX_W-1:0]        fill_idx_d;

   // The last held cycle of a beat, and the last beat of a line.
   assign beat_last  = (wait_q == WAIT_LAST);
   assign line_last  = beat_last && (cnt_q == CNT_LAST);

   // Fill word index; with critical-word-first it rotates from the requested word.
   assign fill_idx_q = cnt_q + cwf_off_q;
   assign fill_idx_d = cnt_d + cwf_off_d;

   // Next state: request capture, beat and hold counting, fill data capture.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wait_d      = wait_q;
      wb_base_d   = wb_base_q;
      fill_base_d = fill_base_q;
      wb_line_d   = wb_line_q;
      fill_flag_d = fill_flag_q;
      cwf_off_d   = cwf_off_q;
      fill_line_d = fill_line_q;

      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               wb_base_d   = line_base(wb_addr_i);
               fill_base_d = line_base(fill_addr_i);
               wb_line_d   = wb_line_i;
               fill_flag_d = req_fill_i;
`ifdef MEM_LINE_CWF_EN
               cwf_off_d   = fill_addr_i[IDX_W:1];
`else
               cwf_off_d   = '0;
`endif
               cnt_d       = '0;
               wait_d      = '0;
               if (req_wb_i) begin
                  state_d = WB;
               end else if (req_fill_i) begin
                  state_d = FILL;
               end else begin
                  state_d = DONE;
               end
            end
         end

         WB, FILL: begin
            // Read data is combinational, so take it on the beat's final held cycle.
            if ((state_q == FILL) && beat_last) begin
               fill_line_d[16*fill_idx_q +: 16] = mem_rdata_i;
            end
            if (line_last) begin
               cnt_d   = '0;
               wait_d  = '0;
               state_d = ((state_q == WB) && fill_flag_q) ? FILL : DONE;
            end else if (beat_last) begin
               cnt_d  = cnt_q + 1'b1;
               wait_d = '0;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Memory-side values for the coming cycle, derived from the next state so they can be registered.
   always_comb begin
      mem_en_d    = 1'b0;
      mem_wr_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      case (state_d)
         WB: begin
            mem_en_d    = 1'b1;
            mem_wr_d    = 1'b1;
            mem_addr_d  = beat_addr(wb_base_d, cnt_d);
            mem_wdata_d = wb_line_d[16*cnt_d +: 16];
         end
         FILL: begin
            mem_en_d    = 1'b1;
            mem_addr_d  = beat_addr(fill_base_d, fill_idx_d);
         end
         default: begin
         end
      endcase
   end

   // State and datapath registers; reset abandons any burst and clears the outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wait_q      <= '0;
         wb_base_q   <= '0;
         fill_base_q <= '0;
         wb_line_q   <= '0;
         fill_flag_q <= 1'b0;
         cwf_off_q   <= '0;
         fill_line_q <= '0;
         mem_en_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wait_q      <= wait_d;
         wb_base_q   <= wb_base_d;
         fill_base_q <= fill_base_d;
         wb_line_q   <= wb_line_d;
         fill_flag_q <= fill_flag_d;
         cwf_off_q   <= cwf_off_d;
         fill_line_q <= fill_line_d;
         mem_en_q    <= mem_en_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign req_ready_o = (state_q == IDLE);
   assign busy_o      = ~req_ready_o;
   assign done_o      = (state_q == DONE);
   assign fill_line_o = fill_line_q;
   assign mem_en_o    = mem_en_q;
   assign mem_wr_o    = mem_wr_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_line_master.sv
// Bench for mem_line_master: two instances (WAIT_CYCLES 0 and 2), each with
// its own behavioural memory, driven with identical requests. A reference
// model checks the per-cycle memory traffic, and a table supplies hand-computed
// latencies and fill results.
`timescale 1ns/1ps
module tb_mem_line_master;

   localparam int WORDS = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req_valid, req_wb, req_fill;
   logic [15:0] wb_addr, fill_addr;
   logic [63:0] wb_line;
   logic        ready [2];
   logic        done  [2];
   logic        busy  [2];
   logic        en    [2];
   logic        wr    [2];
   logic [15:0] addr  [2];
   logic [15:0] wdata [2];
   logic [15:0] rdata [2];
   logic [63:0] fline [2];
   logic        pl_we;
   logic [14:0] pl_a;
   logic [15:0] pl_d;

   int checks   = 0;
   int failures = 0;

   function automatic logic [15:0] pat(input int idx);
      return 16'((idx * 40503) ^ 23100);
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [15:0] mem [0:32767];
      initial for (int i = 0; i < 32768; i++) mem[i] = pat(i);
      always @(posedge clk) begin
         if (pl_we) mem[pl_a] <= pl_d;
         else if (en[g] && wr[g]) mem[addr[g][15:1]] <= wdata[g];
      end
      assign rdata[g] = mem[addr[g][15:1]];

      mem_line_master #(.WORDS(WORDS), .ADDR_WIDTH(16), .WAIT_CYCLES(2*g)) u_dut (
         .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(ready[g]),
         .req_wb_i(req_wb), .req_fill_i(req_fill), .wb_addr_i(wb_addr), .fill_addr_i(fill_addr),
         .wb_line_i(wb_line), .fill_line_o(fline[g]), .done_o(done[g]), .busy_o(busy[g]),
         .mem_en_o(en[g]), .mem_wr_o(wr[g]), .mem_addr_o(addr[g]), .mem_wdata_o(wdata[g]),
         .mem_rdata_i(rdata[g]));
   end

   // ---------------- reference model ----------------
   logic [15:0] ref_mem [int];
   logic [63:0] model_fill;

   typedef struct packed {
      logic        en;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic        done;
   } beat_t;
   beat_t trq0[$];
   beat_t trq1[$];

   function automatic logic [15:0] ref_rd(input logic [15:0] a);
      int i;
      i = int'(a[15:1]);
      return ref_mem.exists(i) ? ref_mem[i] : pat(i);
   endfunction

   task automatic push_beat(input int d, input beat_t b);
      if (d == 0) trq0.push_back(b);
      else        trq1.push_back(b);
   endtask

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      pl_we = 1'b1; pl_a = a[15:1]; pl_d = d;
      @(posedge clk);
      @(negedge clk);
      pl_we = 1'b0;
      ref_mem[int'(a[15:1])] = d;
   endtask

   // Issue one request to both instances and check every cycle until both are idle.
   task automatic run_req(input string nm, input bit wb, input bit fill,
                          input logic [15:0] wa, input logic [15:0] fa, input logic [63:0] wl,
                          input bit use_tab, input int tlat0, input int tlat2,
                          input logic [63:0] tfill);
      logic [15:0] wbase, fbase;
      logic [63:0] efill;
      int c, w, idx, jmax;
      int len  [2];
      int dcyc [2];
      beat_t e;
      wbase = wa & 16'hFFF8;
      fbase = fa & 16'hFFF8;
      c = 0;
`ifdef MEM_LINE_CWF_EN
      c = int'(fa[2:1]);
`endif
      trq0.delete();
      trq1.delete();
      for (int d = 0; d < 2; d++) begin
         w = 2 * d;
         if (wb)
            for (int k = 0; k < WORDS; k++)
               for (int r = 0; r <= w; r++)
                  push_beat(d, '{1'b1, 1'b1, wbase + 16'(2*k), wl[16*k +: 16], 1'b0});
         if (fill)
            for (int k = 0; k < WORDS; k++) begin
               idx = (c + k) % WORDS;
               for (int r = 0; r <= w; r++)
                  push_beat(d, '{1'b1, 1'b0, fbase + 16'(2*idx), 16'h0, 1'b0});
            end
         push_beat(d, '{1'b0, 1'b0, 16'h0, 16'h0, 1'b1});
      end
      if (wb)
         for (int k = 0; k < WORDS; k++)
            ref_mem[int'((wbase + 16'(2*k)) >> 1)] = wl[16*k +: 16];
      efill = model_fill;
      if (fill)
         for (int k = 0; k < WORDS; k++)
            efill[16*k +: 16] = ref_rd(fbase + 16'(2*k));
      model_fill = efill;
      len[0] = trq0.size();
      len[1] = trq1.size();
      dcyc[0] = 0;
      dcyc[1] = 0;

      req_wb = wb; req_fill = fill; wb_addr = wa; fill_addr = fa; wb_line = wl;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_wb    = 1'($urandom);
      req_fill  = 1'($urandom);
      wb_addr   = 16'($urandom);
      fill_addr = 16'($urandom);
      wb_line   = {$urandom, $urandom};

      jmax = ((len[0] > len[1]) ? len[0] : len[1]) + 1;
      for (int j = 1; j <= jmax; j++) begin
         for (int d = 0; d < 2; d++) begin
            if (j <= len[d]) begin
               e = (d == 0) ? trq0[j-1] : trq1[j-1];
               chk($sformatf("%s.w%0d.cyc%0d", nm, 2*d, j),
                   {en[d], wr[d], e.en ? addr[d] : 16'h0, e.wr ? wdata[d] : 16'h0, done[d], busy[d]},
                   {e.en, e.wr, e.addr, e.wdata, e.done, 1'b1});
               if (done[d] && dcyc[d] == 0) dcyc[d] = j;
               if (j == len[d]) begin
                  chk($sformatf("%s.w%0d.fill_model", nm, 2*d), fline[d], efill);
                  if (use_tab) chk($sformatf("%s.w%0d.fill_tab", nm, 2*d), fline[d], tfill);
               end
            end else if (j == len[d] + 1) begin
               chk($sformatf("%s.w%0d.idle", nm, 2*d), {ready[d], done[d], en[d], wr[d]}, 4'b1000);
            end
         end
         @(negedge clk);
      end
      if (use_tab) begin
         chk($sformatf("%s.w0.latency", nm), dcyc[0], tlat0);
         chk($sformatf("%s.w2.latency", nm), dcyc[1], tlat2);
      end
   endtask

   function automatic logic [15:0] pick();
      return ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                         : 16'($urandom_range(0, 255));
   endfunction

   typedef struct {
      string       nm;
      bit          wb;
      bit          fill;
      logic [15:0] wa;
      logic [15:0] fa;
      logic [63:0] wl;
      int          lat0;
      int          lat2;
      logic [63:0] fl;
   } vec_t;
   vec_t tab [8];

   initial begin
      tab[0] = '{"fill40",    1'b0, 1'b1, 16'h0000, 16'h0040, 64'h0,                   5, 13, 64'h4444_3333_2222_1111};
      tab[1] = '{"wbfill",    1'b1, 1'b1, 16'h0100, 16'h0200, 64'hDDDD_CCCC_BBBB_AAAA, 9, 25, 64'h8888_7777_6666_5555};
      tab[2] = '{"wrap",      1'b0, 1'b1, 16'h0000, 16'hFFF8, 64'h0,                   5, 13, 64'hCCCC_BBBB_AAAA_9999};
      tab[3] = '{"noflag",    1'b0, 1'b0, 16'h0100, 16'h0040, 64'h1234_5678_9ABC_DEF0, 1,  1, 64'hCCCC_BBBB_AAAA_9999};
      tab[4] = '{"wbonly",    1'b1, 1'b0, 16'h0306, 16'h0040, 64'h0123_4567_89AB_CDEF, 5, 13, 64'hCCCC_BBBB_AAAA_9999};
      tab[5] = '{"rdback100", 1'b0, 1'b1, 16'h0000, 16'h0106, 64'h0,                   5, 13, 64'hDDDD_CCCC_BBBB_AAAA};
      tab[6] = '{"cwf44",     1'b0, 1'b1, 16'h0000, 16'h0044, 64'h0,                   5, 13, 64'h4444_3333_2222_1111};
      tab[7] = '{"wb40rd300", 1'b1, 1'b1, 16'h0040, 16'h0302, 64'hFEDC_BA98_7654_3210, 9, 25, 64'h0123_4567_89AB_CDEF};

      rst_n = 1'b0; req_valid = 1'b0; req_wb = 1'b0; req_fill = 1'b0;
      wb_addr = '0; fill_addr = '0; wb_line = '0;
      pl_we = 1'b0; pl_a = '0; pl_d = '0; model_fill = '0;

      // reset state
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset.w%0d.ctl", 2*d), {ready[d], done[d], busy[d], en[d], wr[d], addr[d], wdata[d]},
             {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0});
         chk($sformatf("reset.w%0d.fill", 2*d), fline[d], 64'h0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      preload(16'h0040, 16'h1111); preload(16'h0042, 16'h2222);
      preload(16'h0044, 16'h3333); preload(16'h0046, 16'h4444);
      preload(16'h0200, 16'h5555); preload(16'h0202, 16'h6666);
      preload(16'h0204, 16'h7777); preload(16'h0206, 16'h8888);
      preload(16'hFFF8, 16'h9999); preload(16'hFFFA, 16'hAAAA);
      preload(16'hFFFC, 16'hBBBB); preload(16'hFFFE, 16'hCCCC);

      // asynchronous reset during beat 2 of a fill
      req_fill = 1'b1; req_wb = 1'b0; fill_addr = 16'h0040; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst.w0.beat2", {en[0], wr[0], addr[0], busy[0]}, {1'b1, 1'b0, 16'h0044, 1'b1});
      chk("midrst.w2.busy", {en[1], busy[1]}, 2'b11);
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++)
         chk($sformatf("midrst.w%0d.async", 2*d), {en[d], wr[d], busy[d], ready[d], addr[d], fline[d]},
             {1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 64'h0});
      model_fill = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++)
            chk($sformatf("midrst.w%0d.nodone", 2*d), {done[d], ready[d], en[d]}, 3'b010);
      end

      // directed table
      for (int i = 0; i < 8; i++)
         run_req(tab[i].nm, tab[i].wb, tab[i].fill, tab[i].wa, tab[i].fa, tab[i].wl,
                 1'b1, tab[i].lat0, tab[i].lat2, tab[i].fl);

      // randomized requests against the reference model
      for (int i = 0; i < 24; i++) begin
         bit          rwb, rfl;
         logic [15:0] ra, rf;
         logic [63:0] rl;
         rwb = 1'($urandom_range(0, 1));
         rfl = 1'($urandom_range(0, 1));
         ra  = pick();
         rf  = pick();
         rl  = {$urandom, $urandom};
         run_req($sformatf("rnd%0d", i), rwb, rfl, ra, rf, rl, 1'b0, 0, 0, 64'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_line_master.md
Name: mem_line_master

Overview:
- Initiator-side controller for the single-cycle, byte-addressable, 16-bit memory interface (enable / wr / addr / data_in / data_out).
- Converts one cache-line request into a sequence of word beats: an optional writeback of a dirty line, then an optional fill of a new line.
- Sits between the cache miss handler and the data/instruction memory.
- Returns the filled line as one wide bus with a one-cycle done pulse.

Parameters:
- WORDS, 4: 16-bit words per line; power of two, 2..16.
- ADDR_WIDTH, 16: byte-address width, matching the memory.
- WAIT_CYCLES, 0: extra cycles each beat is held, to model slower memory; 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle, can accept a request.
- req_wb  in  1  request includes a writeback of wb_line.
- req_fill  in  1  request includes a fill.
- wb_addr  in  ADDR_WIDTH  byte address of the line to write back.
- fill_addr  in  ADDR_WIDTH  byte address of the line to fill.
- wb_line  in  16*WORDS  writeback data; word i is bits [16i+15:16i].
- fill_line  out  16*WORDS  filled line, same word packing as wb_line.
- done  out  1  one-cycle pulse when the request completes.
- busy  out  1  request in progress; equals ~req_ready.
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  memory byte address; bit 0 is always 0.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data; combinational, valid in the same cycle.

Behaviour:
- Reset (rst low, asynchronous): state returns to IDLE. req_ready=1. done, busy, mem_en and mem_wr are 0. mem_addr, mem_wdata and fill_line are 0. All memory-side outputs are registered, so they drop immediately with no glitch beat.
- Reset mid-operation: abandons the current burst. No done pulse is issued. fill_line is cleared.
- FSM states: IDLE, WB, FILL, DONE.
- IDLE: req_ready=1. On req_valid at a rising edge:
  - Latch wb_addr, fill_addr, wb_line and the req_wb/req_fill flags.
  - Next state is WB if req_wb, else FILL if req_fill, else DONE.
- Line base address = addr with its low log2(2*WORDS) bits cleared. The offset bits of wb_addr/fill_addr are ignored, except as noted under the optional feature.
- Beat k drives mem_addr = base + 2k (k = 0..WORDS-1) and holds mem_en=1 for WAIT_CYCLES+1 consecutive cycles. Beats are back-to-back; no gap between beats.
- WB: mem_wr=1, mem_wdata = word k of the latched line. Each held cycle rewrites the same word, which is harmless. After the last beat, go to FILL if the fill flag is set, else DONE. WB→FILL has no idle cycle; mem_wr falls and mem_addr changes on the same edge.
- FILL: mem_wr=0. On the final cycle of each beat, mem_rdata is captured into word k of fill_line. After the last beat, go to DONE.
- DONE: done=1 and req_ready=0 for exactly one cycle, then IDLE.
- fill_line holds its value from DONE until the next fill beat overwrites it. A writeback-only request leaves fill_line unchanged.
- Latency from the accept edge to the done cycle = (nwb + nfill)·WORDS·(WAIT_CYCLES+1) + 1, where nwb and nfill are 0 or 1 per the request flags.
- A request with neither flag set goes straight to DONE: done one cycle after accept, no memory activity.
- mem_en is never asserted in IDLE or DONE, so concurrent read and write never occurs.
- Address wrap: base + 2k is computed modulo 2^ADDR_WIDTH. A line at the top of memory does not carry out.
- req_valid while busy is ignored; inputs are not sampled. Request inputs need only be stable at the accept edge.

Optional Feature:
- Macro: MEM_LINE_CWF_EN.
- Defined: critical-word-first fill. The fill starts at word c = fill_addr word offset and proceeds c, c+1, ..., wrapping modulo WORDS. Each word is still placed at its natural index in fill_line. Writeback order is unchanged (0..WORDS-1).
- Undefined: fills always start at word 0, and the fill_addr offset is ignored.

Test Plan:
- Reset then fill-only with fill_addr=0x0040, WORDS=4, WAIT_CYCLES=0, memory words 0x1111..0x4444:
  - mem_addr sequence 0x40, 0x42, 0x44, 0x46 with mem_wr=0.
  - done in cycle 5 after accept; fill_line=0x4444_3333_2222_1111.
- Writeback + fill with wb_addr=0x0100, fill_addr=0x0200, wb_line=0xDDDD_CCCC_BBBB_AAAA:
  - Writes 0xAAAA@0x100 .. 0xDDDD@0x106, then reads 0x200..0x206 with no idle cycle between.
  - done in cycle 9; readback of 0x100..0x106 matches wb_line.
- WAIT_CYCLES=2, fill-only: each mem_addr is held 3 cycles; done in cycle 13; data is captured on the third cycle of each beat.
- Wrap case: fill_addr=0xFFF8, WORDS=4 gives addresses 0xFFF8..0xFFFE. Neither-flag request gives done one cycle after accept with mem_en never asserted.
- Async reset asserted during beat 2 of a fill: mem_en, mem_wr and busy go to 0 immediately with no clock edge needed; no done pulse; a new request after reset completes normally.
- MEM_LINE_CWF_EN defined, fill_addr=0x0044: read order 0x44, 0x46, 0x40, 0x42; fill_line is identical to the non-CWF result.
